// File: rtl/msk_skinny_arb.sv
// rtl/msk_skinny_arb.sv - two-requester arbiter and operand sequencer for a masked SKINNY core
// Optional macro ARB_ROUND_ROBIN_EN: round-robin grant on contention (default: requester 0 wins)
module msk_skinny_arb #(
  parameter int d = 2,
  localparam int NRND = 16*d*(d-1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_last,
  input  logic [1:0][127:0]     req_tk1,
  input  logic [1:0][127:0]     req_tk2,
  input  logic [1:0][128*d-1:0] req_key,
  input  logic [1:0][128*d-1:0] req_pt,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [128*d-1:0]      resp_ct,
  input  logic [NRND-1:0]       rnd_in,
  output logic [NRND-1:0]       core_rnd,
  output logic                  core_start,
  output logic                  core_last,
  output logic [127:0]          core_tk1,
  output logic [127:0]          core_tk2,
  output logic [128*d-1:0]      core_key,
  output logic [128*d-1:0]      core_pt,
  input  logic [128*d-1:0]      core_ct,
  input  logic                  core_done,
  output logic                  busy,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t             state_q, state_d;
  logic               grant_q, grant_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               last_q, last_d;
  logic [1:0]         rv_q, rv_d;
  logic [127:0]       tk1_q, tk1_d, tk2_q, tk2_d;
  logic [128*d-1:0]   key_q, key_d, pt_q, pt_d, ct_q, ct_d;
  logic               win;
  logic               hs;
`ifdef ARB_ROUND_ROBIN_EN
  logic               ptr_q, ptr_d;
`endif

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    win = (req_valid == 2'b11) ? ptr_q : req_valid[1];
`else
    win = req_valid[1] & ~req_valid[0];
`endif
    // req_ready is forced low while reset is held, even though it is combinational
    req_ready = 2'b00;
    if (reset && (state_q == IDLE) && req_valid[win]) req_ready[win] = 1'b1;
    hs = |(req_valid & req_ready);

    state_d = state_q;
    grant_d = grant_q;
    tk1_d   = tk1_q;
    tk2_d   = tk2_q;
    key_d   = key_q;
    pt_d    = pt_q;
    last_d  = last_q;
    ct_d    = ct_q;
    err_d   = err_q | (core_done & (state_q != RUN));
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d   = hs ? ~win : ptr_q;
`endif
    case (state_q)
      IDLE: if (hs) begin
        state_d = LOAD;
        grant_d = win;
        tk1_d   = req_tk1[win];
        tk2_d   = req_tk2[win];
        key_d   = req_key[win];
        pt_d    = req_pt[win];
        last_d  = req_last[win];
      end
      LOAD: state_d = RUN;
      RUN: if (core_done) begin
        ct_d    = core_ct;
        state_d = RESP;
      end
      RESP: if (resp_ready[grant_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    start_d = (state_d == LOAD);
    busy_d  = (state_d != IDLE);
    rv_d    = 2'b00;
    if (state_d == RESP) rv_d[grant_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      rv_q    <= 2'b00;
      tk1_q   <= '0;
      tk2_q   <= '0;
      key_q   <= '0;
      pt_q    <= '0;
      ct_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      last_q  <= last_d;
      rv_q    <= rv_d;
      tk1_q   <= tk1_d;
      tk2_q   <= tk2_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      ct_q    <= ct_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Fresh randomness reaches the core only while it is computing
  assign core_rnd   = ((state_q == LOAD) || (state_q == RUN)) ? rnd_in : '0;
  assign core_start = start_q;
  assign core_last  = last_q;
  assign core_tk1   = tk1_q;
  assign core_tk2   = tk2_q;
  assign core_key   = key_q;
  assign core_pt    = pt_q;
  assign resp_ct    = ct_q;
  assign resp_valid = rv_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_msk_skinny_arb.sv
// tb/tb_msk_skinny_arb.sv - directed self-checking bench for msk_skinny_arb
module tb_msk_skinny_arb;
  localparam int D  = 2;
  localparam int NR = 16*D*(D-1);

  logic                  clk = 1'b0;
  logic                  reset;
  logic [1:0]            req_valid, req_ready, req_last;
  logic [1:0][127:0]     req_tk1, req_tk2;
  logic [1:0][128*D-1:0] req_key, req_pt;
  logic [1:0]            resp_valid, resp_ready;
  logic [128*D-1:0]      resp_ct;
  logic [NR-1:0]         rnd_in, core_rnd;
  logic                  core_start, core_last, busy, err;
  logic [127:0]          core_tk1, core_tk2;
  logic [128*D-1:0]      core_key, core_pt;
  logic [128*D-1:0]      core_ct = '0;
  logic                  core_done = 1'b0;

  msk_skinny_arb #(.d(D)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
    .req_tk1(req_tk1), .req_tk2(req_tk2), .req_key(req_key), .req_pt(req_pt),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ct(resp_ct),
    .rnd_in(rnd_in), .core_rnd(core_rnd),
    .core_start(core_start), .core_last(core_last),
    .core_tk1(core_tk1), .core_tk2(core_tk2), .core_key(core_key), .core_pt(core_pt),
    .core_ct(core_ct), .core_done(core_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Stand-in for the masked cipher: a simple share-wise mix of the operands
  function automatic logic [255:0] fct(input logic [127:0] t1, input logic [127:0] t2,
                                       input logic [255:0] k, input logic [255:0] p);
    return p ^ k ^ {t1, t2};
  endfunction

  // Core model: done pulses core_lat cycles after start; ct is scrambled once idle
  int            core_lat = 40;
  int            cnt = 0;
  logic [255:0]  ct_hold = '0;
  always @(negedge clk) begin
    core_done = 1'b0;
    if (cnt != 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        core_done = 1'b1;
        core_ct   = ct_hold;
      end
    end else begin
      core_ct = ~ct_hold;
    end
    if (core_start) begin
      cnt     = core_lat;
      ct_hold = fct(core_tk1, core_tk2, core_key, core_pt);
    end
  end

  logic [255:0] exp_ct [2];

  task automatic run_txn(output logic g);
    int n;
    n = 0;
    #1;
    while (req_ready == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
    check_eq("txn_hs", 256'(|req_ready), 256'(1'b1));
    g = req_ready[1];
    @(negedge clk);
    n = 0;
    while (resp_valid == 2'b00 && n < 200) begin @(negedge clk); n++; end
    check_eq("txn_resp_valid", 256'(resp_valid), g ? 256'(2'b10) : 256'(2'b01));
    check_eq("txn_resp_ct", resp_ct, exp_ct[g]);
    resp_ready = resp_valid;
    @(negedge clk);
    resp_ready = 2'b00;
    #1;
  endtask

  initial begin
    int   n, starts, busy_bad;
    logic g;
    logic exp_g;

    reset      = 1'b0;
    req_valid  = 2'b11;
    req_last   = 2'b00;
    resp_ready = 2'b00;
    rnd_in     = 32'hdeadbeef;
    req_tk1[0] = 128'hea135685849431216bee303e087f8a46;
    req_tk2[0] = 128'hea23fb1553a96a09f684ca58ffc33ea7;
    req_key[0] = {128'h0, 128'h544480d81a2483237c795768a7444ec3};
    req_pt[0]  = {128'h0, 128'ha42757d2ace7ce858ba9b1a3215a899d};
    req_tk1[1] = 128'h0123456789abcdef0011223344556677;
    req_tk2[1] = 128'hfedcba98765432108899aabbccddeeff;
    req_key[1] = {128'h1111222233334444555566667777aaaa, 128'h0f0e0d0c0b0a09080706050403020100};
    req_pt[1]  = {128'h5a5a5a5a5a5a5a5aa5a5a5a5a5a5a5a5, 128'h00112233445566778899aabbccddeeff};
    for (int i = 0; i < 2; i++) exp_ct[i] = fct(req_tk1[i], req_tk2[i], req_key[i], req_pt[i]);

    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", 256'(req_ready), '0);
    check_eq("rst_resp_valid", 256'(resp_valid), '0);
    check_eq("rst_busy", 256'(busy), '0);
    check_eq("rst_err", 256'(err), '0);
    check_eq("rst_core_start", 256'(core_start), '0);
    check_eq("rst_core_rnd", 256'(core_rnd), '0);
    check_eq("rst_core_key", core_key, '0);
    check_eq("rst_resp_ct", resp_ct, '0);

    // Single request from requester 0, 40-cycle core
    req_valid = 2'b00;
    reset     = 1'b1;
    @(negedge clk);
    req_valid = 2'b01;
    req_last  = 2'b01;
    #1;
    check_eq("hs_ready", 256'(req_ready), 256'(2'b01));
    @(negedge clk);
    req_valid = 2'b00;
    check_eq("load_start", 256'(core_start), 256'(1'b1));
    check_eq("load_busy", 256'(busy), 256'(1'b1));
    check_eq("load_tk1", 256'(core_tk1), 256'(req_tk1[0]));
    check_eq("load_tk2", 256'(core_tk2), 256'(req_tk2[0]));
    check_eq("load_key", core_key, req_key[0]);
    check_eq("load_pt", core_pt, req_pt[0]);
    check_eq("load_last", 256'(core_last), 256'(1'b1));
    check_eq("load_rnd", 256'(core_rnd), 256'(rnd_in));
    n = 1; starts = 1; busy_bad = 0;
    while (resp_valid == 2'b00 && n < 100) begin
      @(negedge clk);
      n++;
      if (core_start) starts++;
      if (!busy) busy_bad++;
    end
    check_eq("latency", 256'(n), 256'(42));
    check_eq("start_count", 256'(starts), 256'(1));
    check_eq("busy_gap", 256'(busy_bad), '0);
    check_eq("resp_valid0", 256'(resp_valid), 256'(2'b01));
    check_eq("resp_ct0", resp_ct, exp_ct[0]);
    check_eq("resp_unmasked0", 256'(resp_ct[127:0] ^ resp_ct[255:128]),
             256'(exp_ct[0][127:0] ^ exp_ct[0][255:128]));
    check_eq("resp_rnd", 256'(core_rnd), '0);

    // Stall in RESP with a foreign resp_ready and a pending request
    req_valid  = 2'b10;
    resp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check_eq("stall_valid", 256'(resp_valid), 256'(2'b01));
      check_eq("stall_ct", resp_ct, exp_ct[0]);
      check_eq("stall_ready", 256'(req_ready), '0);
      check_eq("stall_rnd", 256'(core_rnd), '0);
    end
    req_valid  = 2'b00;
    resp_ready = 2'b01;
    @(negedge clk);
    resp_ready = 2'b00;
    check_eq("idle_valid", 256'(resp_valid), '0);
    check_eq("idle_busy", 256'(busy), '0);
    check_eq("idle_rnd", 256'(core_rnd), '0);
    check_eq("idle_ct_hold", resp_ct, exp_ct[0]);

    // Contention for four transactions from a fresh reset
    reset = 1'b0;
    @(negedge clk);
    reset     = 1'b1;
    core_lat  = 3;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      run_txn(g);
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = k[0];
`else
      exp_g = 1'b0;
`endif
      check_eq("contend_grant", 256'(g), 256'(exp_g));
    end
    req_valid = 2'b00;
    @(negedge clk);

    // Reset mid-RUN, stray done afterwards, then a normal transaction
    core_lat  = 40;
    req_valid = 2'b10;
    #1;
    check_eq("abort_hs", 256'(req_ready), 256'(2'b10));
    @(negedge clk);
    req_valid = 2'b00;
    repeat (11) @(negedge clk);
    check_eq("abort_run_busy", 256'(busy), 256'(1'b1));
    check_eq("abort_run_rnd", 256'(core_rnd), 256'(rnd_in));
    reset     = 1'b0;
    req_valid = 2'b11;
    #1;
    check_eq("abort_ready", 256'(req_ready), '0);
    check_eq("abort_busy", 256'(busy), '0);
    check_eq("abort_start", 256'(core_start), '0);
    check_eq("abort_rnd", 256'(core_rnd), '0);
    check_eq("abort_valid", 256'(resp_valid), '0);
    check_eq("abort_tk2", 256'(core_tk2), '0);
    check_eq("abort_pt", core_pt, '0);
    check_eq("abort_err", 256'(err), '0);
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 2'b00;
    n = 0;
    while (!err && n < 60) begin @(negedge clk); n++; end
    check_eq("stray_done_err", 256'(err), 256'(1'b1));
    req_valid = 2'b01;
    run_txn(g);
    req_valid = 2'b00;
    check_eq("after_abort_grant", 256'(g), '0);
    check_eq("err_sticky", 256'(err), 256'(1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/msk_skinny_arb.md
MSK_SKINNY_ARB -- requirements
Module: msk_skinny_arb

Interface
REQ-001 Parameter: d, 2, number of Boolean shares per masked bit; NRND = 16*d*(d-1) derived, width of the randomness bus.
REQ-002 Ports: clk  in  1  system clock, all state on rising edge.
REQ-003 Ports: reset  in  1  asynchronous, active-low reset.
REQ-004 Ports: req_valid  in  2  per-requester request; req_ready  out  2  per-requester accept, one-hot or zero.
REQ-005 Ports: req_last  in  2  per-requester last-block flag; req_tk1, req_tk2  in  2x128  per-requester tweakey words; req_key  in  2x128*d  masked key; req_pt  in  2x128*d  masked plaintext.
REQ-006 Ports: resp_valid  out  2  per-requester result valid; resp_ready  in  2  per-requester result accept; resp_ct  out  128*d  masked ciphertext, shared by both requesters.
REQ-007 Ports: rnd_in  in  NRND  fresh randomness; core_rnd  out  NRND  randomness to the core.
REQ-008 Ports: core_start, core_last  out  1 each; core_tk1, core_tk2  out  128 each; core_key, core_pt  out  128*d each.
REQ-009 Ports: core_ct  in  128*d  core output; core_done  in  1  core completion; busy  out  1  high when not IDLE; err  out  1  sticky protocol error.

Function
REQ-010 FSM states: IDLE, LOAD, RUN, RESP.
REQ-011 IDLE: grant = arbitration winner among asserted req_valid; req_ready[grant] = 1, combinational, only in IDLE.
REQ-012 Handshake req_valid[g] & req_ready[g]: latch tk1/tk2/key/pt/last of g into operand registers, latch g, go to LOAD.
REQ-013 core_tk1/tk2/key/pt/last driven from operand registers only, stable from LOAD until leaving RUN.
REQ-014 LOAD: core_start = 1 for exactly one cycle, then RUN; core_start = 0 in every other state.
REQ-015 RUN: wait for core_done; on core_done latch core_ct into resp_ct register and go to RESP in the same edge.
REQ-016 RESP: resp_valid[grant] = 1, other bit 0; on resp_ready[grant] go to IDLE; new request accepted no earlier than the following cycle.
REQ-017 resp_ct holds its value from entry into RESP until the next RUN completion.
REQ-018 core_rnd = rnd_in in LOAD and RUN; all-zero in IDLE and RESP.
REQ-019 Latency: request handshake in cycle t -> core_start at t+1; core_done at t+1+N -> resp_valid at t+2+N.
REQ-020 core_done in IDLE, LOAD or RESP: ignored for data, sets err; err cleared only by reset.
REQ-021 resp_ready for a non-granted requester, or outside RESP: no effect.
REQ-022 Simultaneous req_valid on both requesters: exactly one granted; the other waits with req_ready = 0.

Reset
REQ-023 reset low, at any time including mid-RUN: state = IDLE, req_ready = 0 until reset released, resp_valid = 0, core_start = 0, core_rnd = 0, busy = 0, err = 0, operand and resp_ct registers = 0, grant pointer = requester 0.
REQ-024 core_done arriving after reset deassertion for an aborted operation sets err per REQ-020.

Configuration
REQ-025 Macro ARB_ROUND_ROBIN_EN defined: on contention, grant the requester not served last; pointer updates on each request handshake.
REQ-026 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins contention; pointer logic absent.

Verification
REQ-027 Single request, requester 0, tk1=ea135685849431216bee303e087f8a46, tk2=ea23fb1553a96a09f684ca58ffc33ea7, key=544480d81a2483237c795768a7444ec3, pt=a42757d2ace7ce858ba9b1a3215a899d (d=2, share 1 = 0) -> one core_start, core operands equal inputs, unmasked resp_ct equals the SKINNY reference-model ciphertext, resp_valid = 01.
REQ-028 Both req_valid high continuously for 4 transactions -> RR_EN: grants 0,1,0,1; without macro: 0,0,0,0.
REQ-029 Core model with core_done 40 cycles after core_start -> resp_valid rises 42 cycles after the request handshake, busy high throughout.
REQ-030 reset pulled low 10 cycles into RUN -> all outputs zero within the reset cycle; later core_done sets err = 1; next request completes normally.
REQ-031 resp_ready held low 5 cycles in RESP -> resp_valid and resp_ct stable, req_ready stays 0; core_rnd all-zero in IDLE and RESP.
